// File: rtl/mano_io_pkg.sv
// Shared definitions for the basic computer's FGI/FGO peripheral endpoint.
package mano_io_pkg;

    localparam int CHAR_W_DEF = 8;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_SEND = 2'd1,
        O_GAP  = 2'd2
    } out_state_e;

    localparam logic FGO_RST = 1'b1;

endpackage

// File: rtl/mano_io_port_if.sv
// Bus between the I/O endpoint and its CPU, keyboard and printer neighbours.
interface mano_io_port_if #(
    parameter int CHAR_W = 8
);
    logic [CHAR_W-1:0] inpr;
    logic              fgi;
    logic              clr_fgi;
    logic [CHAR_W-1:0] outr_in;
    logic              ld_outr;
    logic [CHAR_W-1:0] outr;
    logic              fgo;
    logic              out_ovr;
    logic              kbd_valid;
    logic [CHAR_W-1:0] kbd_data;
    logic              kbd_ready;
    logic              prn_valid;
    logic [CHAR_W-1:0] prn_data;
    logic              prn_ready;

    modport slave (
        output inpr, fgi, outr, fgo, out_ovr, kbd_ready, prn_valid, prn_data,
        input  clr_fgi, outr_in, ld_outr, kbd_valid, kbd_data, prn_ready
    );

    modport master (
        input  inpr, fgi, outr, fgo, out_ovr, kbd_ready, prn_valid, prn_data,
        output clr_fgi, outr_in, ld_outr, kbd_valid, kbd_data, prn_ready
    );
endinterface

// File: rtl/io_sync_fifo.sv
// Small synchronous FIFO used as the keyboard character buffer.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_o    = mem_q[rd_ptr_q];

    // Storage, wrapping pointers and occupancy; memory is cleared so inpr reads 0 after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
        end
    end
endmodule

// File: rtl/mano_io_port.sv
// Peripheral endpoint driving FGI/INPR from a keyboard buffer and FGO/OUTR toward a printer.
module mano_io_port
    import mano_io_pkg::*;
#(
    parameter int CHAR_W    = CHAR_W_DEF,
    parameter int KBD_DEPTH = 4,
    parameter int PRN_GAP   = 3
) (
    input  logic           CLK,
    input  logic           RST,
    mano_io_port_if.slave  io
);
    localparam int GAP_W = (PRN_GAP > 1) ? $clog2(PRN_GAP) : 1;

    logic              full_s;
    logic              empty_s;
    logic [CHAR_W-1:0] head_s;
    logic              fgi_s;
    logic              pop_s;
    logic              recover_q;

    out_state_e        state_q, state_d;
    logic [CHAR_W-1:0] outr_q, outr_d;
    logic              fgo_q, fgo_d;
    logic              prn_valid_q, prn_valid_d;
    logic              ovr_q, ovr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    io_sync_fifo #(
        .WIDTH (CHAR_W),
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (io.kbd_valid),
        .data_i  (io.kbd_data),
        .pop_i   (pop_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .head_o  (head_s)
    );

    // The recover cycle forces a low FGI after every pop so each character gets its own flag edge.
    assign fgi_s = ~empty_s & ~recover_q;
    assign pop_s = io.clr_fgi & fgi_s;

    assign io.inpr      = head_s;
    assign io.fgi       = fgi_s;
    assign io.kbd_ready = ~full_s;
    assign io.outr      = outr_q;
    assign io.prn_data  = outr_q;
    assign io.fgo       = fgo_q;
    assign io.prn_valid = prn_valid_q;
    assign io.out_ovr   = ovr_q;

    // Input-side recover flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            recover_q <= 1'b0;
        end else begin
            recover_q <= pop_s;
        end
    end

    // Output channel state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= O_IDLE;
            outr_q      <= '0;
            fgo_q       <= FGO_RST;
            prn_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            outr_q      <= outr_d;
            fgo_q       <= fgo_d;
            prn_valid_q <= prn_valid_d;
            ovr_q       <= ovr_d;
            gap_q       <= gap_d;
        end
    end

    // Output FSM next state; a load outside O_IDLE (even on the edge fgo rises) is only flagged.
    always_comb begin
        state_d     = state_q;
        outr_d      = outr_q;
        fgo_d       = fgo_q;
        prn_valid_d = prn_valid_q;
        ovr_d       = ovr_q;
        gap_d       = gap_q;
        case (state_q)
            O_IDLE: begin
                if (io.ld_outr) begin
                    outr_d      = io.outr_in;
                    fgo_d       = 1'b0;
                    prn_valid_d = 1'b1;
                    state_d     = O_SEND;
                end else begin
                    fgo_d = 1'b1;
                end
            end
            O_SEND: begin
                if (io.ld_outr) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (io.prn_ready) begin
                    prn_valid_d = 1'b0;
                    if (PRN_GAP == 0) begin
                        fgo_d   = 1'b1;
                        state_d = O_IDLE;
                    end else begin
                        gap_d   = GAP_W'(PRN_GAP - 1);
                        state_d = O_GAP;
                    end
                end else begin
                    prn_valid_d = 1'b1;
                end
            end
            O_GAP: begin
                if (io.ld_outr) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (gap_q == '0) begin
                    fgo_d   = 1'b1;
                    state_d = O_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d     = O_IDLE;
                fgo_d       = FGO_RST;
                prn_valid_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mano_io_port.sv
// Directed vector table plus randomized run against a queue-based model of the I/O endpoint.
module tb_mano_io_port;
    localparam int DEPTH = 4;
    localparam int GAP   = 3;

    typedef struct {
        logic       rst, kv;
        logic [7:0] kd;
        logic       clr, ld;
        logic [7:0] oin;
        logic       pr;
        logic       fgi;
        logic [7:0] inpr;
        logic       kr, fgo, pv;
        logic [7:0] outr;
        logic       ovr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mano_io_port_if #(.CHAR_W(8)) bus();

    mano_io_port #(.CHAR_W(8), .KBD_DEPTH(DEPTH), .PRN_GAP(GAP)) dut (
        .CLK (clk),
        .RST (rst),
        .io  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: keyboard queue and output channel expressed as deadlines.
    logic [7:0] mq [$];
    logic       m_rec, m_idle, m_send, m_ovr;
    logic [7:0] m_outr;
    int         m_rise, edge_n;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic kv, input logic [7:0] kd, input logic clr,
                         input logic ld, input logic [7:0] oin, input logic pr);
        rst           = r;
        bus.kbd_valid = kv;
        bus.kbd_data  = kd;
        bus.clr_fgi   = clr;
        bus.ld_outr   = ld;
        bus.outr_in   = oin;
        bus.prn_ready = pr;
    endtask

    function automatic vec_t mk(input logic r, input logic kv, input logic [7:0] kd,
                                input logic clr, input logic ld, input logic [7:0] oin,
                                input logic pr, input logic fgi, input logic [7:0] inpr,
                                input logic kr, input logic fgo, input logic pv,
                                input logic [7:0] outr, input logic ovr);
        vec_t v;
        v.rst = r; v.kv = kv; v.kd = kd; v.clr = clr; v.ld = ld; v.oin = oin; v.pr = pr;
        v.fgi = fgi; v.inpr = inpr; v.kr = kr; v.fgo = fgo; v.pv = pv; v.outr = outr;
        v.ovr = ovr;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic kv, input logic [7:0] kd,
                              input logic clr, input logic ld, input logic [7:0] oin,
                              input logic pr);
        logic fgi_m, pop, push;
        if (r) begin
            mq.delete();
            m_rec = 1'b0; m_idle = 1'b1; m_send = 1'b0; m_ovr = 1'b0; m_outr = 8'h00;
        end else begin
            fgi_m = (mq.size() > 0) && !m_rec;
            pop   = clr && fgi_m;
            push  = kv && (mq.size() < DEPTH);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(kd);
            m_rec = pop;
            if (m_idle) begin
                if (ld) begin
                    m_outr = oin; m_idle = 1'b0; m_send = 1'b1;
                end
            end else begin
                if (ld) m_ovr = 1'b1;
                if (m_send) begin
                    if (pr) begin
                        m_send = 1'b0;
                        if (GAP == 0) m_idle = 1'b1;
                        else m_rise = edge_n + GAP;
                    end
                end else if (edge_n == m_rise) begin
                    m_idle = 1'b1;
                end
            end
        end
        edge_n++;
    endtask

    vec_t tbl [$];

    initial begin
        logic       r, kv, clr, ld, pr, fgi_e;
        logic [7:0] kd, oin;

        m_rise = -1;
        edge_n = 0;
        apply(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        //              rst kv  kd     clr ld  oin    pr  | fgi inpr  kr  fgo pv  outr   ovr
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h41, 0, 0, 8'h00, 0,   1, 8'h41, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h42, 0, 0, 8'h00, 0,   1, 8'h41, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h43, 0, 0, 8'h00, 0,   1, 8'h41, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 8'h00, 0,   1, 8'h41, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h45, 0, 0, 8'h00, 0,   1, 8'h41, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h45, 1, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h45, 0, 0, 8'h00, 0,   1, 8'h42, 0, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,   1, 8'h43, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,   1, 8'h44, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h46, 1, 1, 8'h5A, 1,   0, 8'h00, 1, 0, 1, 8'h5A, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h45, 1, 0, 0, 8'h5A, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h45, 1, 0, 0, 8'h5A, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h45, 1, 0, 0, 8'h5A, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h45, 1, 1, 0, 8'h5A, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h31, 0,   1, 8'h45, 1, 0, 1, 8'h31, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h32, 0,   1, 8'h45, 1, 0, 1, 8'h31, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,   1, 8'h45, 1, 0, 0, 8'h31, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,   1, 8'h45, 1, 0, 0, 8'h31, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,   1, 8'h45, 1, 0, 0, 8'h31, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h33, 0,   1, 8'h45, 1, 1, 0, 8'h31, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h77, 0,   1, 8'h45, 1, 0, 1, 8'h77, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 1, 8'h55, 0, 0, 8'h00, 0,   1, 8'h55, 1, 1, 0, 8'h00, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i].rst, tbl[i].kv, tbl[i].kd, tbl[i].clr, tbl[i].ld, tbl[i].oin,
                  tbl[i].pr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_fgi", i), bus.fgi, tbl[i].fgi);
            if (tbl[i].fgi || tbl[i].rst) chk($sformatf("v%0d_inpr", i), bus.inpr, tbl[i].inpr);
            chk($sformatf("v%0d_kbd_ready", i), bus.kbd_ready, tbl[i].kr);
            chk($sformatf("v%0d_fgo", i), bus.fgo, tbl[i].fgo);
            chk($sformatf("v%0d_prn_valid", i), bus.prn_valid, tbl[i].pv);
            chk($sformatf("v%0d_outr", i), bus.outr, tbl[i].outr);
            chk($sformatf("v%0d_prn_data", i), bus.prn_data, tbl[i].outr);
            chk($sformatf("v%0d_out_ovr", i), bus.out_ovr, tbl[i].ovr);
        end

        // Randomized phase starts from a reset so the model and DUT agree.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            r   = (c == 0) || ($urandom_range(0, 149) == 0);
            kv  = 1'($urandom_range(0, 1));
            kd  = 8'($urandom);
            clr = ($urandom_range(0, 2) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            oin = 8'($urandom);
            pr  = 1'($urandom_range(0, 1));
            apply(r, kv, kd, clr, ld, oin, pr);
            @(posedge clk);
            model_step(r, kv, kd, clr, ld, oin, pr);
            #1;
            fgi_e = (mq.size() > 0) && !m_rec;
            chk("rnd_fgi", bus.fgi, fgi_e);
            if (fgi_e) chk("rnd_inpr", bus.inpr, mq[0]);
            chk("rnd_kbd_ready", bus.kbd_ready, mq.size() < DEPTH);
            chk("rnd_fgo", bus.fgo, m_idle);
            chk("rnd_prn_valid", bus.prn_valid, m_send);
            chk("rnd_outr", bus.outr, m_outr);
            chk("rnd_prn_data", bus.prn_data, m_outr);
            chk("rnd_out_ovr", bus.out_ovr, m_ovr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
